mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single SRAM port, with a per-access timeout.
// Three states: IDLE grants a request, BUSY holds it on the SRAM port, DONE pulses the winner's ready.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    output logic        m0_err,

    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        m1_err,

    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    input  logic        s_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       last_grant;   // 1 = m1 was granted last
    logic       grant;        // master owning the access in flight
    logic       pick_m1;

    // m1 wins when alone, or when both request and m0 was granted last.
    always_comb begin
        pick_m1 = m1_valid && (!m0_valid || !last_grant);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            s_valid    <= 1'b0;
            s_addr     <= 32'd0;
            s_wdata    <= 32'd0;
            s_wstrb    <= 4'd0;
            m0_rdata   <= 32'd0;
            m1_rdata   <= 32'd0;
            m0_ready   <= 1'b0;
            m1_ready   <= 1'b0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
        end else begin
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            m0_err   <= 1'b0;
            m1_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        grant      <= pick_m1;
                        last_grant <= pick_m1;
                        s_valid    <= 1'b1;
                        s_addr     <= pick_m1 ? m1_addr  : m0_addr;
                        s_wdata    <= pick_m1 ? m1_wdata : m0_wdata;
                        s_wstrb    <= pick_m1 ? m1_wstrb : m0_wstrb;
                        cnt        <= 8'd0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    // A response on the final cycle still counts as a normal completion.
                    if (s_ready) begin
                        s_valid <= 1'b0;
                        state   <= DONE;
                        if (grant) begin
                            m1_rdata <= s_rdata;
                            m1_ready <= 1'b1;
                        end else begin
                            m0_rdata <= s_rdata;
                            m0_ready <= 1'b1;
                        end
                    end else if (cnt == CNT_LAST) begin
                        s_valid <= 1'b0;
                        state   <= DONE;
                        if (grant) begin
                            m1_rdata <= 32'd0;
                            m1_ready <= 1'b1;
                            m1_err   <= 1'b1;
                        end else begin
                            m0_rdata <= 32'd0;
                            m0_ready <= 1'b1;
                            m0_err   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    s_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, hand-written reset/drop/idle sequences, then random
// transactions checked against a transaction-level model (round-robin winner, SRAM delay vs timeout).
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready, m0_err, m1_err;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata;
    logic        s_ready;

    int checks;
    int failures;
    int last_g;

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_s_wdata", s_wdata, 32'd0);
        chk("rst_s_wstrb", 32'(s_wstrb), 32'd0);
        chk("rst_ready", 32'({m0_ready, m1_ready, m0_err, m1_err}), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
    endtask

    // Starts and ends at a negedge where the DUT is (or is about to be) in IDLE.
    // d = number of s_valid-high cycles after which s_ready is presented; 0 = never.
    task automatic run_txn(
        input logic v0, input logic v1,
        input logic [31:0] a0, input logic [31:0] a1,
        input logic [31:0] wd0, input logic [31:0] wd1,
        input logic [3:0] st0, input logic [3:0] st1,
        input int d, input logic [31:0] data,
        input bit drop_early, input bit hold,
        output int out_w, output logic out_err, output logic [31:0] out_rd);
        int w, hi, exp_hi;
        bit done;
        logic exp_err;
        logic [31:0] ea, ew, exp_rd;
        logic [3:0] es;

        w = (v0 && v1) ? ((last_g == 1) ? 0 : 1) : (v0 ? 0 : 1);
        last_g = w;
        ea = (w == 1) ? a1 : a0;
        ew = (w == 1) ? wd1 : wd0;
        es = (w == 1) ? st1 : st0;
        exp_err = !(d >= 1 && d <= TO);
        exp_hi  = exp_err ? TO : d;
        exp_rd  = exp_err ? 32'd0 : data;
        out_w = -1; out_err = 1'b0; out_rd = 32'd0;

        chk("gap_s_valid", 32'(s_valid), 32'd0);
        m0_valid = v0; m0_addr = a0; m0_wdata = wd0; m0_wstrb = st0;
        m1_valid = v1; m1_addr = a1; m1_wdata = wd1; m1_wstrb = st1;
        s_ready = 1'b0; s_rdata = data;
        hi = 0; done = 0;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clk);
            if (m0_ready || m1_ready) begin
                done = 1;
                out_w   = m0_ready ? 0 : 1;
                out_err = m0_ready ? m0_err : m1_err;
                out_rd  = m0_ready ? m0_rdata : m1_rdata;
                chk("latency", 32'(cyc), 32'(exp_hi + 1));
                chk("s_valid_cycles", 32'(hi), 32'(exp_hi));
                chk("m0_ready", 32'(m0_ready), 32'(w == 0));
                chk("m1_ready", 32'(m1_ready), 32'(w == 1));
                chk("rdata", out_rd, exp_rd);
                chk("err", 32'(out_err), 32'(exp_err));
                chk("done_s_valid", 32'(s_valid), 32'd0);
                s_ready = 1'b0;
                if (!hold) begin
                    m0_valid = 1'b0;
                    m1_valid = 1'b0;
                end
            end else if (s_valid) begin
                hi++;
                chk("s_addr", s_addr, ea);
                chk("s_wdata", s_wdata, ew);
                chk("s_wstrb", 32'(s_wstrb), 32'(es));
                s_ready = (hi == d);
                if (drop_early) begin
                    m0_valid = 1'b0;
                    m1_valid = 1'b0;
                end
            end else begin
                s_ready = 1'b0;
            end
        end
        if (!done) begin
            failures++;
            checks++;
            $display("FAIL wait_ready: no ready pulse within 60 cycles");
        end
        @(negedge clk);
        chk("pulse_end", 32'({m0_ready, m1_ready, m0_err, m1_err}), 32'd0);
        chk("rdata_hold", (w == 1) ? m1_rdata : m0_rdata, exp_rd);
    endtask

    typedef struct {
        logic v0, v1;
        logic [31:0] a0, a1, wd0, wd1;
        logic [3:0] st0, st1;
        int d;
        logic [31:0] data;
        bit hold;
        int ew;
        logic eerr;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int ow;
        logic oerr;
        logic [31:0] ord;

        checks = 0; failures = 0; last_g = 1;
        m0_valid = 0; m1_valid = 0; m0_addr = 0; m1_addr = 0;
        m0_wdata = 0; m1_wdata = 0; m0_wstrb = 0; m1_wstrb = 0;
        s_rdata = 0; s_ready = 0;

        //        v0 v1  a0          a1          wd0           wd1           st0   st1   d  data          hold ew eerr erd
        tbl[0] = '{1, 0, 32'h10,     32'h0,      32'h0,        32'h0,        4'h0, 4'h0, 1, 32'h12345678, 0,   0, 0, 32'h12345678};
        tbl[1] = '{0, 1, 32'h0,      32'h20,     32'h0,        32'hAABBCCDD, 4'h0, 4'h1, 3, 32'hCAFE0001, 0,   1, 0, 32'hCAFE0001};
        tbl[2] = '{1, 1, 32'h100,    32'h200,    32'h11111111, 32'h22222222, 4'hF, 4'h3, 2, 32'h0A0A0A0A, 1,   0, 0, 32'h0A0A0A0A};
        tbl[3] = '{1, 1, 32'h100,    32'h200,    32'h11111111, 32'h22222222, 4'hF, 4'h3, 1, 32'h0B0B0B0B, 1,   1, 0, 32'h0B0B0B0B};
        tbl[4] = '{1, 1, 32'h100,    32'h200,    32'h11111111, 32'h22222222, 4'hF, 4'h3, 4, 32'h0C0C0C0C, 1,   0, 0, 32'h0C0C0C0C};
        tbl[5] = '{1, 0, 32'h30,     32'h0,      32'h0,        32'h0,        4'h0, 4'h0, 0, 32'hFFFFFFFF, 0,   0, 1, 32'h0};
        tbl[6] = '{0, 1, 32'h0,      32'h40,     32'h0,        32'h0,        4'h0, 4'h0, 4, 32'h5555AAAA, 0,   1, 0, 32'h5555AAAA};
        tbl[7] = '{1, 1, 32'h50,     32'h60,     32'h1,        32'h2,        4'h2, 4'h4, 5, 32'h77777777, 1,   0, 1, 32'h0};
        tbl[8] = '{1, 1, 32'h50,     32'h60,     32'h1,        32'h2,        4'h2, 4'h4, 1, 32'h88888888, 0,   1, 0, 32'h88888888};

        rst = 1'b1;
        #1;
        chk_reset_vals();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_g = 1;
        @(negedge clk);
        chk_reset_vals();

        foreach (tbl[i]) begin
            run_txn(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].a1, tbl[i].wd0, tbl[i].wd1,
                    tbl[i].st0, tbl[i].st1, tbl[i].d, tbl[i].data, 1'b0, tbl[i].hold,
                    ow, oerr, ord);
            chk($sformatf("tbl%0d_winner", i), 32'(ow), 32'(tbl[i].ew));
            chk($sformatf("tbl%0d_err", i), 32'(oerr), 32'(tbl[i].eerr));
            chk($sformatf("tbl%0d_rdata", i), ord, tbl[i].erd);
        end

        // s_ready while idle must not start or complete anything
        s_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_sready_s_valid", 32'(s_valid), 32'd0);
            chk("idle_sready_ready", 32'({m0_ready, m1_ready}), 32'd0);
        end
        s_ready = 1'b0;

        // Master withdraws valid during BUSY: access still completes
        run_txn(1, 0, 32'h70, 32'h0, 32'h9, 32'h0, 4'h8, 4'h0, 3, 32'h13579BDF, 1'b1, 1'b0, ow, oerr, ord);
        chk("drop_winner", 32'(ow), 32'd0);

        // Reset in BUSY abandons the access; contention afterwards goes to m0
        m1_valid = 1'b1; m1_addr = 32'h80; m1_wdata = 32'h0; m1_wstrb = 4'h0;
        s_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_s_valid", 32'(s_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_s_valid", 32'(s_valid), 32'd0);
        chk("async_rst_ready", 32'({m0_ready, m1_ready}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m1_valid = 1'b0;
        last_g = 1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_ready", 32'({m0_ready, m1_ready}), 32'd0);
            chk("post_rst_s_valid", 32'(s_valid), 32'd0);
        end
        run_txn(1, 1, 32'h90, 32'hA0, 32'h0, 32'h0, 4'h0, 4'h0, 1, 32'h2468ACE0, 1'b0, 1'b0, ow, oerr, ord);
        chk("post_rst_winner", 32'(ow), 32'd0);

        // Randomized transactions against the model inside run_txn
        for (int n = 0; n < 40; n++) begin
            int pat;
            pat = $urandom_range(1, 3);
            run_txn(pat[0], pat[1], $urandom, $urandom, $urandom, $urandom,
                    4'($urandom), 4'($urandom), $urandom_range(0, 6), $urandom,
                    1'($urandom_range(0, 3) == 0), 1'b0, ow, oerr, ord);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
